// File: rtl/lsu_bus.sv
// lsu_bus: multi-cycle load/store unit with region decode, valid/ready bus, timeout and fault causes.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/SH/W/SW accesses (cause 2) without a bus transaction.
module lsu_bus #(
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]    DMEM_BASE      = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0]    DMEM_SIZE      = ADDR_WIDTH'(32'h0200_0000),
  parameter logic [ADDR_WIDTH-1:0]    MMIO_BASE      = ADDR_WIDTH'(32'h4000_0000),
  parameter logic [ADDR_WIDTH-1:0]    MMIO_SIZE      = ADDR_WIDTH'(32'h0000_1000),
  parameter int unsigned              TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [1:0]            resp_cause,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_resp_valid,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ACCESS   = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // Timeout fires on the cycle the counter holds TIMEOUT_CYCLES-1, i.e. after TIMEOUT_CYCLES cycles in REQ+WAIT.
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W     = (TO_LAST_I < 2) ? 1 : $clog2(TO_LAST_I + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  // Region bounds widened by one bit so a region ending at 2^ADDR_WIDTH does not wrap.
  localparam logic [ADDR_WIDTH:0] DMEM_LO = {1'b0, DMEM_BASE};
  localparam logic [ADDR_WIDTH:0] DMEM_HI = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};
  localparam logic [ADDR_WIDTH:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [ADDR_WIDTH:0] MMIO_HI = {1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE};

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic [1:0]              resp_cause_q, resp_cause_d;
  logic                    bus_req_valid_q, bus_req_valid_d;
  logic                    bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]              bus_be_q, bus_be_d;
  logic [31:0]             bus_wdata_q, bus_wdata_d;

  logic [ADDR_WIDTH:0]     addr_ext;
  logic                    hit;
  logic                    misalign;
  logic                    timeout_hit;
  logic [3:0]              st_be;
  logic [31:0]             st_wdata;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             ld_data;

  assign addr_ext    = {1'b0, req_addr};
  assign hit         = ((addr_ext >= DMEM_LO) && (addr_ext < DMEM_HI)) ||
                       ((addr_ext >= MMIO_LO) && (addr_ext < MMIO_HI));
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0])
      misalign = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
      misalign = 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          st_be    = 4'b0001 << req_addr[1:0];
          st_wdata = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          st_be    = 4'b0011 << req_addr[1:0];
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'(bus_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    resp_cause_d = CAUSE_NONE;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (misalign) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_MISALIGN;
          end else if (!hit) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_ACCESS;
          end else begin
            state_d     = S_REQ;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
          end
        end
      end
      S_REQ: begin
        cnt_d = TO_EN ? cnt_q + CNT_W'(1) : '0;
        if (timeout_hit) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
        end else if (bus_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = TO_EN ? cnt_q + CNT_W'(1) : '0;
        if (bus_resp_valid) begin
          state_d      = S_RESP;
          resp_rdata_d = bus_we_q ? 32'h0 : ld_data;
        end else if (timeout_hit) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    resp_valid_d    = (state_d == S_RESP);
    bus_req_valid_d = (state_d == S_REQ);
    req_ready_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      resp_cause_q    <= '0;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_be_q        <= '0;
      bus_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      resp_cause_q    <= resp_cause_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_be_q        <= bus_be_d;
      bus_wdata_q     <= bus_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign resp_cause    = resp_cause_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
